eco32_wb_timer_mc: RTL

Multi-channel Wishbone B3 timer and the parametrised successor of the single-channel ECO32 `tmr` peripheral on the eco32f SoC.
- Provides NUM_CH independent down-counters behind one shared prescaler.
- Each channel supports periodic or one-shot mode, a run gate and write-1-to-clear expiry.
- Sits on the wb_intercon `timer0` slave port; `irq_o` feeds `eco32_irq[14]` and up.

---
 rtl/eco32_timer_pkg.sv | 30 +++
 rtl/eco32_timer_ch.sv | 95 +++++++++
 rtl/eco32_wb_timer_mc.sv | 121 ++++++++++++
 3 files changed

// File: rtl/eco32_timer_pkg.sv
// Shared constants and helpers for the multi-channel ECO32 Wishbone timer.
// Holds the register map, CTRL bit positions and the byte-lane merge rule.
package eco32_timer_pkg;

    localparam int CH_STRIDE = 16;

    localparam logic [3:0] OFF_CTRL = 4'h0;
    localparam logic [3:0] OFF_DIV  = 4'h4;
    localparam logic [3:0] OFF_CNT  = 4'h8;

    localparam logic [7:0] ADR_PRESCALE = 8'h80;
    localparam logic [7:0] ADR_STATUS   = 8'h84;

    localparam int CTRL_EXP     = 0;
    localparam int CTRL_IEN     = 1;
    localparam int CTRL_RUN     = 2;
    localparam int CTRL_ONESHOT = 3;

    // Byte lanes with sel=0 keep the register's current contents.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = sel[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/eco32_timer_ch.sv
// One timer channel: CTRL, DIV and CNT registers plus the per-tick
// countdown, expiry and one-shot logic.
module eco32_timer_ch
    import eco32_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    input  logic             i_ctrl_we,
    input  logic             i_div_we,
    input  logic             i_cnt_we,
    input  logic [31:0]      i_wdat,
    input  logic [3:0]       i_sel,
    output logic             o_exp,
    output logic             o_ien,
    output logic             o_run,
    output logic             o_oneshot,
    output logic [CNT_W-1:0] o_div,
    output logic [CNT_W-1:0] o_cnt
);

    logic             r_exp, r_ien, r_run, r_oneshot;
    logic [CNT_W-1:0] r_div, r_cnt;
    logic             w_ctrl_lane, w_w1c, w_stop, w_tick_en, w_expire;
    logic [31:0]      w_div_m, w_cnt_m;
    logic [CNT_W-1:0] w_div_wr, w_cnt_wr;
    logic             w_unused;

    // All CTRL fields live in byte lane 0.
    assign w_ctrl_lane = i_ctrl_we & i_sel[0];
    assign w_w1c       = w_ctrl_lane & i_wdat[CTRL_EXP];
    assign w_stop      = w_ctrl_lane & ~i_wdat[CTRL_RUN];
    assign w_tick_en   = i_tick & r_run & ~w_stop;
    assign w_expire    = w_tick_en & (r_cnt == CNT_W'(1));

    assign w_div_m  = lane_merge(32'(r_div), i_wdat, i_sel);
    assign w_cnt_m  = lane_merge(32'(r_cnt), i_wdat, i_sel);
    assign w_div_wr = w_div_m[CNT_W-1:0];
    assign w_cnt_wr = w_cnt_m[CNT_W-1:0];
    assign w_unused = &{1'b0, w_div_m, w_cnt_m};

    // NOTE: non-blocking assignments so every register sees pre-edge values.
    // NOTE: every bit is reset because reset state is visible on the bus.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exp     <= 1'b0;
            r_ien     <= 1'b0;
            r_run     <= 1'b0;
            r_oneshot <= 1'b0;
            r_div     <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_ctrl_lane) begin
                r_ien     <= i_wdat[CTRL_IEN];
                r_oneshot <= i_wdat[CTRL_ONESHOT];
            end

            if (w_expire && r_oneshot) begin
                r_run <= 1'b0;
            end else if (w_ctrl_lane) begin
                r_run <= i_wdat[CTRL_RUN];
            end

            // Expiry beats a simultaneous write-1-to-clear.
            if (w_expire) begin
                r_exp <= 1'b1;
            end else if (w_w1c) begin
                r_exp <= 1'b0;
            end

            if (i_div_we) begin
                r_div <= w_div_wr;
            end

            // Bus writes beat the tick; CNT of 0 or 1 reloads from DIV.
            if (i_cnt_we) begin
                r_cnt <= w_cnt_wr;
            end else if (i_div_we) begin
                r_cnt <= w_div_wr;
            end else if (w_tick_en) begin
                r_cnt <= (r_cnt <= CNT_W'(1)) ? r_div : r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_exp     = r_exp;
    assign o_ien     = r_ien;
    assign o_run     = r_run;
    assign o_oneshot = r_oneshot;
    assign o_div     = r_div;
    assign o_cnt     = r_cnt;

endmodule

// File: rtl/eco32_wb_timer_mc.sv
// Multi-channel Wishbone B3 timer: bus decode, read mux, shared prescaler
// and interrupt combine around NUM_CH eco32_timer_ch instances.
module eco32_wb_timer_mc
    import eco32_timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic [7:0]        wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [NUM_CH-1:0] irq_o,
    output logic              irq_any_o
);

    logic              w_req, w_valid, w_wr_ch, w_tick;
    logic              w_is_pre, w_is_stat, w_is_ch;
    logic [7:0]        w_adr;
    logic [3:0]        w_ch_idx, w_off;
    logic [31:0]       w_rdata, w_pre_m;
    logic [PRE_W-1:0]  r_prescale, r_pre_cnt;
    logic [NUM_CH-1:0] w_ctrl_we, w_div_we, w_cnt_we;
    logic [NUM_CH-1:0] w_exp, w_ien, w_run, w_oneshot;
    logic [CNT_W-1:0]  w_div [NUM_CH];
    logic [CNT_W-1:0]  w_cnt [NUM_CH];
    logic              w_unused;

    // Gating on ack/err enforces one wait state between accesses.
    assign w_req     = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign w_adr     = {wb_adr_i[7:2], 2'b00};
    assign w_ch_idx  = 4'(int'(w_adr) / CH_STRIDE);
    assign w_off     = 4'(int'(w_adr) % CH_STRIDE);
    assign w_is_pre  = (w_adr == ADR_PRESCALE);
    assign w_is_stat = (w_adr == ADR_STATUS);
    assign w_is_ch   = (int'(w_ch_idx) < NUM_CH);
    assign w_valid   = w_is_pre | w_is_stat | w_is_ch;
    assign w_wr_ch   = w_req & wb_we_i & w_is_ch;

    assign w_pre_m  = lane_merge(32'(r_prescale), wb_dat_i, wb_sel_i);
    assign w_tick   = (r_pre_cnt == '0);
    assign w_unused = &{1'b0, wb_adr_i[1:0], w_pre_m};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_ctrl_we[g] = w_wr_ch && (w_ch_idx == 4'(g)) && (w_off == OFF_CTRL);
        assign w_div_we[g]  = w_wr_ch && (w_ch_idx == 4'(g)) && (w_off == OFF_DIV);
        assign w_cnt_we[g]  = w_wr_ch && (w_ch_idx == 4'(g)) && (w_off == OFF_CNT);

        eco32_timer_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .i_clk     (wb_clk_i),
            .i_rst_n   (wb_rst_ni),
            .i_tick    (w_tick),
            .i_ctrl_we (w_ctrl_we[g]),
            .i_div_we  (w_div_we[g]),
            .i_cnt_we  (w_cnt_we[g]),
            .i_wdat    (wb_dat_i),
            .i_sel     (wb_sel_i),
            .o_exp     (w_exp[g]),
            .o_ien     (w_ien[g]),
            .o_run     (w_run[g]),
            .o_oneshot (w_oneshot[g]),
            .o_div     (w_div[g]),
            .o_cnt     (w_cnt[g])
        );
    end

    always_comb begin
        // NOTE: default first so no path through the mux infers a latch.
        w_rdata = '0;
        if (w_is_pre) begin
            w_rdata = 32'(r_prescale);
        end else if (w_is_stat) begin
            w_rdata = 32'(w_exp);
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (w_ch_idx == 4'(n)) begin
                    case (w_off)
                        OFF_CTRL: w_rdata = 32'({w_oneshot[n], w_run[n], w_ien[n], w_exp[n]});
                        OFF_DIV:  w_rdata = 32'(w_div[n]);
                        OFF_CNT:  w_rdata = 32'(w_cnt[n]);
                        default:  w_rdata = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_ack_o   <= 1'b0;
            wb_err_o   <= 1'b0;
            wb_dat_o   <= '0;
            r_prescale <= '0;
            r_pre_cnt  <= '0;
        end else begin
            wb_ack_o <= w_req & w_valid;
            wb_err_o <= w_req & ~w_valid;
            if (w_req) begin
                wb_dat_o <= (w_valid && !wb_we_i) ? w_rdata : '0;
            end
            if (w_req && wb_we_i && w_is_pre) begin
                r_prescale <= w_pre_m[PRE_W-1:0];
            end
            r_pre_cnt <= w_tick ? r_prescale : r_pre_cnt - PRE_W'(1);
        end
    end

    assign irq_o     = w_exp & w_ien;
    assign irq_any_o = |irq_o;

endmodule
